bip_addsub_acc: RTL and testbench

- Parametrised, registered add/subtract unit with an internal accumulator for the BIP datapath.
- Replaces the fixed-width combinational subtractor.
- Adds add/sub/accumulate modes, optional saturation, status flags and a valid/ready handshake.
- Sits between the operand-select muxes and the accumulator write-back path.

---
 rtl/bip_addsub_acc.sv | 137 +++++++++++++
 tb/tb_bip_addsub_acc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_addsub_acc.sv
// Registered add/subtract unit with internal accumulator for the BIP datapath.
// One result register behind a valid/ready handshake, optional signed saturation.
module bip_addsub_acc #(
    parameter int WIDTH    = 11,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_c,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_ACCADD = 3'b010;
    localparam logic [2:0] OP_ACCSUB = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_CLR    = 3'b101;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] opx;
    logic [WIDTH-1:0] opy;
    logic [WIDTH-1:0] opy_eff;
    logic             do_sub;
    logic             arith;
    logic             acc_wr;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] res;
    logic             res_v;
    logic             res_c;
    logic             accept;

    // Operand routing: accumulator ops use acc as the first operand and a as the second.
    always_comb begin
        opx    = a;
        opy    = b;
        do_sub = 1'b0;
        arith  = 1'b0;
        acc_wr = 1'b0;
        case (op)
            OP_ADD: begin
                arith = 1'b1;
            end
            OP_SUB: begin
                arith  = 1'b1;
                do_sub = 1'b1;
            end
            OP_ACCADD: begin
                opx    = acc;
                opy    = a;
                arith  = 1'b1;
                acc_wr = 1'b1;
            end
            OP_ACCSUB: begin
                opx    = acc;
                opy    = a;
                arith  = 1'b1;
                do_sub = 1'b1;
                acc_wr = 1'b1;
            end
            OP_LOAD: begin
                acc_wr = 1'b1;
            end
            OP_CLR: begin
                acc_wr = 1'b1;
            end
            default: begin
                arith = 1'b0;
            end
        endcase
    end

    // Subtraction is x + ~y + 1, so the carry out reads as "no borrow".
    assign opy_eff = do_sub ? ~opy : opy;
    assign sum     = {1'b0, opx} + {1'b0, opy_eff} + {{WIDTH{1'b0}}, do_sub};
    assign ovf     = (opx[WIDTH-1] == opy_eff[WIDTH-1]) && (sum[WIDTH-1] != opx[WIDTH-1]);

    always_comb begin
        res   = a;
        res_v = 1'b0;
        res_c = 1'b0;
        if (arith) begin
            res_v = ovf;
            res_c = sum[WIDTH];
            if (SATURATE && ovf) begin
                res = opx[WIDTH-1] ? MAX_NEG : MAX_POS;
            end else begin
                res = sum[WIDTH-1:0];
            end
        end else if (op == OP_CLR) begin
            res = '0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Flags are registered alongside z so they clear with reset and hold when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            flag_c    <= 1'b0;
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            z         <= res;
            flag_z    <= (res == '0);
            flag_n    <= res[WIDTH-1];
            flag_v    <= res_v;
            flag_c    <= res_c;
            if (acc_wr) begin
                acc <= res;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bip_addsub_acc.sv
// Randomised and directed bench for bip_addsub_acc: a wrapping and a saturating
// instance share the same stimulus and are compared against an integer-arithmetic model.
module tb_bip_addsub_acc;

    localparam int W    = 11;
    localparam int MOD  = 2048;
    localparam int SMAX = 1023;
    localparam int SMIN = -1024;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_ready;

    logic         in_ready  [2];
    logic         out_valid [2];
    logic [W-1:0] z         [2];
    logic         flag_z    [2];
    logic         flag_n    [2];
    logic         flag_v    [2];
    logic         flag_c    [2];
    logic [W-1:0] acc       [2];

    int checkCount;
    int errorCount;

    int mValid [2];
    int mZ     [2];
    int mFz    [2];
    int mFn    [2];
    int mFv    [2];
    int mFc    [2];
    int mAcc   [2];

    bip_addsub_acc #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .op(op), .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
        .z(z[0]), .flag_z(flag_z[0]), .flag_n(flag_n[0]), .flag_v(flag_v[0]),
        .flag_c(flag_c[0]), .acc(acc[0])
    );

    bip_addsub_acc #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .op(op), .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
        .z(z[1]), .flag_z(flag_z[1]), .flag_n(flag_n[1]), .flag_v(flag_v[1]),
        .flag_c(flag_c[1]), .acc(acc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int toSigned(input int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    function automatic int toBits(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    // Behavioural result of one operation with plain integer arithmetic.
    function automatic void modelOp(input int opc, input int av, input int bv, input int accv,
                                    input bit sat, output int r, output int v, output int c,
                                    output bit wr);
        int full;
        bit arith;
        full  = 0;
        arith = 1'b0;
        r     = av;
        v     = 0;
        c     = 0;
        wr    = 1'b0;
        case (opc)
            0: begin full = toSigned(av) + toSigned(bv);   c = int'(av + bv >= MOD);   arith = 1'b1; end
            1: begin full = toSigned(av) - toSigned(bv);   c = int'(av >= bv);         arith = 1'b1; end
            2: begin full = toSigned(accv) + toSigned(av); c = int'(accv + av >= MOD); arith = 1'b1; wr = 1'b1; end
            3: begin full = toSigned(accv) - toSigned(av); c = int'(accv >= av);       arith = 1'b1; wr = 1'b1; end
            4: begin r = av; wr = 1'b1; end
            5: begin r = 0;  wr = 1'b1; end
            default: r = av;
        endcase
        if (arith) begin
            v = int'(full > SMAX || full < SMIN);
            if (v != 0 && sat) r = toBits(full > SMAX ? SMAX : SMIN);
            else               r = toBits(full);
        end
    endfunction

    task automatic modelReset();
        for (int u = 0; u < 2; u++) begin
            mValid[u] = 0; mZ[u] = 0; mFz[u] = 0; mFn[u] = 0;
            mFv[u] = 0; mFc[u] = 0; mAcc[u] = 0;
        end
    endtask

    task automatic checkUnit(input int u, input string tag);
        string p;
        p = $sformatf("%s[u%0d]", tag, u);
        checkOutput({p, ".out_valid"}, int'(out_valid[u]), mValid[u]);
        checkOutput({p, ".z"},         int'(z[u]),         mZ[u]);
        checkOutput({p, ".flag_z"},    int'(flag_z[u]),    mFz[u]);
        checkOutput({p, ".flag_n"},    int'(flag_n[u]),    mFn[u]);
        checkOutput({p, ".flag_v"},    int'(flag_v[u]),    mFv[u]);
        checkOutput({p, ".flag_c"},    int'(flag_c[u]),    mFc[u]);
        checkOutput({p, ".acc"},       int'(acc[u]),       mAcc[u]);
    endtask

    // One clock of stimulus: in_ready is checked before the edge, everything else after.
    task automatic applyStimulus(input string tag, input bit vld, input int opc, input int av,
                                 input int bv, input bit ordy);
        bit accepted [2];
        int r, v, c;
        bit wr;
        in_valid  = vld;
        op        = 3'(opc);
        a         = W'(av);
        b         = W'(bv);
        out_ready = ordy;
        #1;
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("%s[u%0d].in_ready", tag, u), int'(in_ready[u]),
                        int'(mValid[u] == 0 || ordy));
            accepted[u] = vld && (mValid[u] == 0 || ordy);
        end
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (accepted[u]) begin
                modelOp(opc, av, bv, mAcc[u], u == 1, r, v, c, wr);
                mValid[u] = 1;
                mZ[u]     = r;
                mFz[u]    = int'(r == 0);
                mFn[u]    = int'(r >= MOD / 2);
                mFv[u]    = v;
                mFc[u]    = c;
                if (wr) mAcc[u] = r;
            end else if (mValid[u] != 0 && ordy) begin
                mValid[u] = 0;
            end
        end
        #1;
        for (int u = 0; u < 2; u++) checkUnit(u, tag);
    endtask

    // Drops rst_n between edges and expects an immediate clear.
    task automatic asyncReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        for (int u = 0; u < 2; u++) begin
            checkUnit(u, tag);
            checkOutput($sformatf("%s[u%0d].in_ready", tag, u), int'(in_ready[u]), 1);
        end
        #1;
        rst_n = 1'b1;
        #1;
        for (int u = 0; u < 2; u++)
            checkOutput($sformatf("%s_rel[u%0d].in_ready", tag, u), int'(in_ready[u]), 1);
    endtask

    function automatic int pickOperand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 0;
            1: return 1;
            2: return SMAX;
            3: return MOD / 2;
            4: return MOD - 1;
            default: return $urandom_range(0, MOD - 1);
        endcase
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        modelReset();
        #2;
        for (int u = 0; u < 2; u++) begin
            checkUnit(u, "reset");
            checkOutput($sformatf("reset[u%0d].in_ready", u), int'(in_ready[u]), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("add_wrap", 1, 0, 1000, 100, 1);
        checkOutput("add_wrap.z_const", int'(z[0]), 'h44C);
        checkOutput("add_sat.z_const", int'(z[1]), SMAX);
        applyStimulus("sub_eq", 1, 1, 5, 5, 1);
        applyStimulus("sub_borrow", 1, 1, 3, 4, 1);
        checkOutput("sub_borrow.z_const", int'(z[0]), MOD - 1);

        applyStimulus("acc_load", 1, 4, 100, 0, 1);
        applyStimulus("acc_add", 1, 2, 23, 0, 1);
        applyStimulus("acc_sub", 1, 3, 200, 0, 1);
        checkOutput("acc_seq.acc_const", int'(acc[0]), MOD - 77);

        applyStimulus("sat_clr", 1, 5, 0, 0, 1);
        applyStimulus("sat_load", 1, 4, 1000, 0, 1);
        applyStimulus("sat_accadd", 1, 2, 100, 0, 1);
        checkOutput("sat_pos.acc_const", int'(acc[1]), SMAX);
        applyStimulus("sat_clr2", 1, 5, 0, 0, 1);
        applyStimulus("sat_loadneg", 1, 4, MOD - 1000, 0, 1);
        applyStimulus("sat_accsub", 1, 3, 100, 0, 1);
        checkOutput("sat_neg.acc_const", int'(acc[1]), MOD / 2);

        applyStimulus("bp_clr", 1, 5, 0, 0, 1);
        applyStimulus("bp_add", 1, 0, 2, 3, 1);
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("bp_stall%0d", i), 1, 2, 7, 0, 0);
        checkOutput("bp_stall.z_const", int'(z[0]), 5);
        applyStimulus("bp_release", 1, 2, 7, 0, 1);
        checkOutput("bp_release.acc_const", int'(acc[0]), 7);
        applyStimulus("bp_drain", 0, 0, 0, 0, 1);

        applyStimulus("rst_clr", 1, 5, 0, 0, 1);
        applyStimulus("rst_load", 1, 4, 123, 0, 0);
        applyStimulus("rst_stall", 1, 0, 1, 1, 0);
        asyncReset("rst_mid");
        applyStimulus("rst_after", 1, 0, 1, 2, 1);

        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                          pickOperand(), pickOperand(), $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
